// File: rtl/daq_rd_sequencer_if.sv
// DAQ link event-word stream between the readout sequencer and downstream.
// DV/DRDY handshake; a word moves on a clock edge with DV & DRDY.
interface daq_rd_sequencer_if;
  logic [15:0] DOUT;
  logic        DV;
  logic        DRDY;
  logic        LAST;

  modport master (
    output DOUT,
    output DV,
    output LAST,
    input  DRDY
  );

  modport slave (
    input  DOUT,
    input  DV,
    input  LAST,
    output DRDY
  );
endinterface

// File: rtl/daq_rd_sequencer.sv
// Readout sequencer: header pop, channel drain, framed 16-bit event stream.
// Optional RDSEQ_CHMASK_EN adds CH_MASK to drop channels from the stream.
module daq_rd_sequencer #(
  parameter int unsigned NCH     = 16,
  parameter logic [3:0]  HDR_KEY = 4'hA
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic [6:0]       SAMP_MAX,
  input  logic             RDY,
  input  logic [43:0]      L1A_SMP_OUT,
  input  logic [191:0]     DOUT_16CH,
`ifdef RDSEQ_CHMASK_EN
  input  logic [NCH-1:0]   CH_MASK,
`endif
  output logic             L1A_RD_EN,
  output logic [NCH-1:0]   RD_ENA,
  output logic             BUSY,
  output logic [15:0]      EVT_CNT,
  daq_rd_sequencer_if.master dq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HPOP,
    S_HWAIT,
    S_HDR,
    S_DATA,
    S_TRL
  } state_t;

  state_t state_q, state_d;

  logic [6:0]     smax_q;
  logic [NCH-1:0] keep_q;
  logic [NCH-1:0] keep_in;
  logic [43:0]    hdr_q;
  logic [3:0]     ch_q;
  logic [6:0]     smp_q;
  logic [1:0]     hcnt_q;
  logic [11:0]    wcnt_q;
  logic           trl_q;
  logic           inf_q;
  logic [3:0]     inf_ch_q;
  logic           inf_keep_q;
  logic [15:0]    evt_q;

  logic [16:0]    buf_q [2];
  logic           rp_q;
  logic           wp_q;
  logic [1:0]     occ_q;

  logic           dv;
  logic [16:0]    head;
  logic           acc;
  logic [2:0]     used;
  logic           room;
  logic           start;
  logic           pop;
  logic           push;
  logic           push_l;
  logic [15:0]    push_w;
  logic [11:0]    samp;
  logic [15:0]    hdr_w;

`ifdef RDSEQ_CHMASK_EN
  assign keep_in = CH_MASK;
`else
  assign keep_in = '1;
`endif

  assign dv      = occ_q != 2'd0;
  assign head    = buf_q[rp_q];
  assign acc     = dv & dq.DRDY;
  assign dq.DV   = dv;
  assign dq.DOUT = dv ? head[15:0] : 16'h0;
  assign dq.LAST = dv & head[16];
  assign BUSY    = state_q != S_IDLE;
  assign EVT_CNT = evt_q;
  assign start   = (state_q == S_IDLE) & ENABLE & RDY;

  // Credit check: the word from a pop issued now lands two edges later,
  // so count what stays in the buffer after this cycle's accept.
  assign used = {1'b0, occ_q} + {2'b0, inf_q};
  assign room = used < (3'd2 + {2'b0, acc});

  assign samp = DOUT_16CH[inf_ch_q*12 +: 12];

  // Header word selected by the header push counter
  always_comb begin
    hdr_w = 16'h0;
    unique case (hcnt_q)
      2'd0: hdr_w = {HDR_KEY, hdr_q[23:12]};
      2'd1: hdr_w = {HDR_KEY, hdr_q[11:0]};
      2'd2: hdr_w = {4'hB, hdr_q[35:24]};
      2'd3: hdr_w = {4'hC, hdr_q[43:36], 4'h0};
      default: hdr_w = 16'h0;
    endcase
  end

  // Next state, pops and buffer pushes
  always_comb begin
    state_d   = state_q;
    L1A_RD_EN = 1'b0;
    pop       = 1'b0;
    push      = inf_q & inf_keep_q;
    push_w    = {inf_ch_q, samp};
    push_l    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HPOP;
      end
      S_HPOP: begin
        L1A_RD_EN = 1'b1;
        state_d   = S_HWAIT;
      end
      S_HWAIT: begin
        state_d = S_HDR;
      end
      S_HDR: begin
        push   = room;
        push_w = hdr_w;
        if (room && hcnt_q == 2'd3) state_d = S_DATA;
      end
      S_DATA: begin
        pop = room;
        if (room && smp_q == smax_q && ch_q == 4'(NCH-1))
          state_d = S_TRL;
      end
      S_TRL: begin
        if (!inf_q && !trl_q && room) begin
          push   = 1'b1;
          push_w = {4'hE, wcnt_q + 12'd1};
          push_l = 1'b1;
        end
        if (acc && head[16]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RD_ENA = pop ? (NCH'(1) << ch_q) : '0;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Event bookkeeping: config latch, counters, in-flight pop tracking
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      smax_q     <= '0;
      keep_q     <= '0;
      hdr_q      <= '0;
      ch_q       <= '0;
      smp_q      <= '0;
      hcnt_q     <= '0;
      wcnt_q     <= '0;
      trl_q      <= 1'b0;
      inf_q      <= 1'b0;
      inf_ch_q   <= '0;
      inf_keep_q <= 1'b0;
      evt_q      <= '0;
    end else begin
      if (start) begin
        smax_q <= SAMP_MAX;
        keep_q <= keep_in;
        ch_q   <= '0;
        smp_q  <= '0;
        hcnt_q <= '0;
        wcnt_q <= '0;
        trl_q  <= 1'b0;
      end
      if (state_q == S_HWAIT) hdr_q <= L1A_SMP_OUT;
      if (state_q == S_HDR && push) hcnt_q <= hcnt_q + 2'd1;
      if (pop) begin
        if (smp_q == smax_q) begin
          smp_q <= '0;
          ch_q  <= ch_q + 4'd1;
        end else begin
          smp_q <= smp_q + 7'd1;
        end
      end
      inf_q      <= pop;
      inf_ch_q   <= ch_q;
      inf_keep_q <= |(keep_q & RD_ENA);
      if (push) wcnt_q <= wcnt_q + 12'd1;
      if (push_l) trl_q <= 1'b1;
      if (state_q == S_TRL && acc && head[16])
        evt_q <= evt_q + 16'd1;
    end
  end

  // Two-entry output buffer holding {last, word}
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rp_q     <= 1'b0;
      wp_q     <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        buf_q[wp_q] <= {push_l, push_w};
        wp_q        <= ~wp_q;
      end
      if (acc) rp_q <= ~rp_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, acc};
    end
  end

endmodule

// File: tb/tb_daq_rd_sequencer.sv
// Bench for daq_rd_sequencer with channel/header FIFO models and scoreboard.
// Channel-mask scenario runs only when RDSEQ_CHMASK_EN is defined.
module tb_daq_rd_sequencer;
  localparam int NCH = 16;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           ENABLE = 1'b0;
  logic [6:0]     SAMP_MAX = 7'd0;
  logic           RDY;
  logic [43:0]    L1A_SMP_OUT;
  logic [191:0]   DOUT_16CH;
  logic           L1A_RD_EN;
  logic [NCH-1:0] RD_ENA;
  logic           BUSY;
  logic [15:0]    EVT_CNT;
`ifdef RDSEQ_CHMASK_EN
  logic [NCH-1:0] CH_MASK = '1;
`endif

  daq_rd_sequencer_if dq();

  daq_rd_sequencer #(.NCH(NCH), .HDR_KEY(4'hA)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .ENABLE(ENABLE),
    .SAMP_MAX(SAMP_MAX),
    .RDY(RDY),
    .L1A_SMP_OUT(L1A_SMP_OUT),
    .DOUT_16CH(DOUT_16CH),
`ifdef RDSEQ_CHMASK_EN
    .CH_MASK(CH_MASK),
`endif
    .L1A_RD_EN(L1A_RD_EN),
    .RD_ENA(RD_ENA),
    .BUSY(BUSY),
    .EVT_CNT(EVT_CNT),
    .dq(dq)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] sval(int k, int i);
    return 12'((k * 293 + i * 7 + 5) % 4096);
  endfunction

  // Channel FIFO models, read latency 1
  logic [11:0] chan_q [NCH] = '{default: 12'h0};
  int          pc [NCH] = '{default: 0};
  always @(posedge CLK)
    for (int k = 0; k < NCH; k++)
      if (RD_ENA[k]) begin
        chan_q[k] <= sval(k, pc[k]);
        pc[k]     <= pc[k] + 1;
      end
  always_comb begin
    DOUT_16CH = '0;
    for (int k = 0; k < NCH; k++) DOUT_16CH[12*k +: 12] = chan_q[k];
  end

  // Header record FIFO model
  logic [43:0] hmem [16];
  int          hwp = 0;
  int          hrp = 0;
  logic [43:0] l1a_q = '0;
  assign RDY = (hwp != hrp);
  assign L1A_SMP_OUT = l1a_q;
  always @(posedge CLK)
    if (L1A_RD_EN) begin
      l1a_q <= hmem[hrp[3:0]];
      hrp   <= hrp + 1;
    end

  int          n_chk = 0;
  int          n_pass = 0;
  logic [16:0] sb [$];
  logic [16:0] seen [$];
  int          exp_pc [NCH] = '{default: 0};
  bit          rand_drdy = 1'b0;
  bit          held = 1'b0;
  logic [16:0] hold_v;
  int          ena_cnt = 0;
  int          l1a_cnt = 0;

  task automatic queue_event(input logic [43:0] rec, input int smax,
                             input logic [NCH-1:0] keep);
    int w;
    logic [11:0] v;
    hmem[hwp[3:0]] = rec;
    hwp = hwp + 1;
    sb.push_back({1'b0, 4'hA, rec[23:12]});
    sb.push_back({1'b0, 4'hA, rec[11:0]});
    sb.push_back({1'b0, 4'hB, rec[35:24]});
    sb.push_back({1'b0, 4'hC, rec[43:36], 4'h0});
    w = 4;
    for (int k = 0; k < NCH; k++)
      for (int s = 0; s <= smax; s++) begin
        v = sval(k, exp_pc[k]);
        exp_pc[k]++;
        if (keep[k]) begin
          sb.push_back({1'b0, 4'(k), v});
          w++;
        end
      end
    sb.push_back({1'b1, 4'hE, 12'(w + 1)});
  endtask

  // One cycle: drive DRDY, then sample the DUT ahead of the next edge
  task automatic tick();
    logic [16:0] e;
    @(negedge CLK);
    if (rand_drdy) dq.DRDY = ($urandom_range(0, 2) != 0);
    #1;
    if (held) begin
      n_chk++;
      if (dq.DV !== 1'b1 || {dq.LAST, dq.DOUT} !== hold_v)
        $display("FAIL hold got=%b/%h want=1/%h", dq.DV,
                 {dq.LAST, dq.DOUT}, hold_v);
      else n_pass++;
    end
    held   = dq.DV & ~dq.DRDY;
    hold_v = {dq.LAST, dq.DOUT};
    if (dq.DV & dq.DRDY) begin
      n_chk++;
      seen.push_back({dq.LAST, dq.DOUT});
      if (sb.size() == 0) begin
        $display("FAIL extra_word got=%h want=none", {dq.LAST, dq.DOUT});
      end else begin
        e = sb.pop_front();
        if ({dq.LAST, dq.DOUT} !== e)
          $display("FAIL word got=%h want=%h", {dq.LAST, dq.DOUT}, e);
        else n_pass++;
      end
    end
    if (RD_ENA != '0) begin
      n_chk++;
      ena_cnt++;
      if (!$onehot(RD_ENA))
        $display("FAIL rd_ena_onehot got=%h want=onehot", RD_ENA);
      else n_pass++;
    end
    if (L1A_RD_EN) l1a_cnt++;
  endtask

  task automatic wait_idle(input int maxc, input int left, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (sb.size() == left && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    dq.DRDY = 1'b1;
    RST_N = 1'b0;
    repeat (3) tick();
    n_chk += 7;
    if (dq.DV !== 1'b0) $display("FAIL rst_dv got=%b want=0", dq.DV);
    else n_pass++;
    if (dq.DOUT !== 16'h0) $display("FAIL rst_dout got=%h want=0", dq.DOUT);
    else n_pass++;
    if (dq.LAST !== 1'b0) $display("FAIL rst_last got=%b want=0", dq.LAST);
    else n_pass++;
    if (BUSY !== 1'b0) $display("FAIL rst_busy got=%b want=0", BUSY);
    else n_pass++;
    if (EVT_CNT !== 16'h0) $display("FAIL rst_evt got=%h want=0", EVT_CNT);
    else n_pass++;
    if (RD_ENA !== '0) $display("FAIL rst_rdena got=%h want=0", RD_ENA);
    else n_pass++;
    if (L1A_RD_EN !== 1'b0) $display("FAIL rst_l1a got=%b want=0", L1A_RD_EN);
    else n_pass++;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_event();
    bit ok;
    int nl;
    logic [43:0] rec;
    rec = {1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 12'hABC, 24'h123456};
    seen.delete();
    ena_cnt = 0;
    l1a_cnt = 0;
    queue_event(rec, 3, '1);
    SAMP_MAX = 7'd3;
    ENABLE = 1'b1;
    wait_idle(400, 0, ok);
    ENABLE = 1'b0;
    nl = 0;
    foreach (seen[i]) if (seen[i][16]) nl++;
    n_chk += 10;
    if (!ok) $display("FAIL single_done got=timeout want=idle");
    else n_pass++;
    if (seen.size() != 69) $display("FAIL single_len got=%0d want=69", seen.size());
    else n_pass++;
    if ((seen.size() > 0 ? seen[0] : 17'hx) !== 17'h0A123)
      $display("FAIL h0 got=%h want=0a123", seen.size() > 0 ? seen[0] : 17'hx);
    else n_pass++;
    if ((seen.size() > 1 ? seen[1] : 17'hx) !== 17'h0A456)
      $display("FAIL h1 got=%h want=0a456", seen.size() > 1 ? seen[1] : 17'hx);
    else n_pass++;
    if ((seen.size() > 2 ? seen[2] : 17'hx) !== 17'h0BABC)
      $display("FAIL h2 got=%h want=0babc", seen.size() > 2 ? seen[2] : 17'hx);
    else n_pass++;
    if ((seen.size() > 3 ? seen[3] : 17'hx) !== 17'h0CA90)
      $display("FAIL h3 got=%h want=0ca90", seen.size() > 3 ? seen[3] : 17'hx);
    else n_pass++;
    if ((seen.size() > 68 ? seen[68] : 17'hx) !== 17'h1E045)
      $display("FAIL trailer got=%h want=1e045", seen.size() > 68 ? seen[68] : 17'hx);
    else n_pass++;
    if (nl != 1) $display("FAIL last_count got=%0d want=1", nl);
    else n_pass++;
    if (EVT_CNT !== 16'd1) $display("FAIL evt1 got=%0d want=1", EVT_CNT);
    else n_pass++;
    if (ena_cnt != 64 || l1a_cnt != 1)
      $display("FAIL pops1 got=%0d/%0d want=64/1", ena_cnt, l1a_cnt);
    else n_pass++;
  endtask

  task automatic test_drdy_random();
    bit ok;
    seen.delete();
    ena_cnt = 0;
    rand_drdy = 1'b1;
    queue_event({8'h5C, 12'h3F1, 24'hFEDCBA}, 7, '1);
    SAMP_MAX = 7'd7;
    ENABLE = 1'b1;
    repeat (10) tick();
    SAMP_MAX = 7'd0;
    ENABLE = 1'b0;
    wait_idle(3000, 0, ok);
    rand_drdy = 1'b0;
    dq.DRDY = 1'b1;
    n_chk += 4;
    if (!ok) $display("FAIL rand_done got=timeout want=idle");
    else n_pass++;
    if (ena_cnt != 128) $display("FAIL rand_pops got=%0d want=128", ena_cnt);
    else n_pass++;
    if (seen.size() != 133) $display("FAIL rand_len got=%0d want=133", seen.size());
    else n_pass++;
    if (EVT_CNT !== 16'd2) $display("FAIL evt2 got=%0d want=2", EVT_CNT);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit ok;
    l1a_cnt = 0;
    queue_event({8'h11, 12'h222, 24'h000333}, 1, '1);
    queue_event({8'h44, 12'h555, 24'h666777}, 1, '1);
    SAMP_MAX = 7'd1;
    ENABLE = 1'b1;
    repeat (5) tick();
    ENABLE = 1'b0;
    wait_idle(500, 37, ok);
    repeat (20) tick();
    n_chk += 5;
    if (!ok) $display("FAIL drop_done got=timeout want=idle");
    else n_pass++;
    if (l1a_cnt != 1) $display("FAIL drop_l1a got=%0d want=1", l1a_cnt);
    else n_pass++;
    if (RDY !== 1'b1) $display("FAIL drop_rdy got=%b want=1", RDY);
    else n_pass++;
    if (BUSY !== 1'b0) $display("FAIL drop_busy got=%b want=0", BUSY);
    else n_pass++;
    if (EVT_CNT !== 16'd3) $display("FAIL evt3 got=%0d want=3", EVT_CNT);
    else n_pass++;
    ENABLE = 1'b1;
    wait_idle(500, 0, ok);
    ENABLE = 1'b0;
    n_chk += 2;
    if (!ok || l1a_cnt != 2)
      $display("FAIL second_evt got=%0b/%0d want=1/2", ok, l1a_cnt);
    else n_pass++;
    if (EVT_CNT !== 16'd4) $display("FAIL evt4 got=%0d want=4", EVT_CNT);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    hit = 1'b0;
    queue_event({8'h77, 12'h888, 24'h999AAA}, 3, '1);
    SAMP_MAX = 7'd3;
    ENABLE = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (RD_ENA[5]) begin
        hit = 1'b1;
        break;
      end
    end
    RST_N = 1'b0;
    ENABLE = 1'b0;
    #1;
    n_chk += 3;
    if (!hit) $display("FAIL mid_ch5 got=timeout want=ch5_pop");
    else n_pass++;
    if ({dq.DV, dq.LAST, dq.DOUT, BUSY, L1A_RD_EN} !== '0 || RD_ENA !== '0)
      $display("FAIL mid_rst_out got=%b%b%h%b%b/%h want=0",
               dq.DV, dq.LAST, dq.DOUT, BUSY, L1A_RD_EN, RD_ENA);
    else n_pass++;
    if (EVT_CNT !== 16'd0) $display("FAIL mid_rst_evt got=%0d want=0", EVT_CNT);
    else n_pass++;
    held = 1'b0;
    sb.delete();
    repeat (2) tick();
    for (int k = 0; k < NCH; k++) exp_pc[k] = pc[k];
    RST_N = 1'b1;
    tick();
    seen.delete();
    ena_cnt = 0;
    queue_event({8'h01, 12'h0F0, 24'h00F00F}, 3, '1);
    ENABLE = 1'b1;
    wait_idle(400, 0, ok);
    ENABLE = 1'b0;
    n_chk += 3;
    if (!ok) $display("FAIL restart_done got=timeout want=idle");
    else n_pass++;
    if (seen.size() != 69 || ena_cnt != 64)
      $display("FAIL restart_len got=%0d/%0d want=69/64", seen.size(), ena_cnt);
    else n_pass++;
    if (EVT_CNT !== 16'd1) $display("FAIL restart_evt got=%0d want=1", EVT_CNT);
    else n_pass++;
  endtask

`ifdef RDSEQ_CHMASK_EN
  task automatic test_chmask();
    bit ok;
    seen.delete();
    ena_cnt = 0;
    CH_MASK = 16'h00FF;
    queue_event({8'h2B, 12'h1D4, 24'h0C0FFE}, 1, 16'h00FF);
    SAMP_MAX = 7'd1;
    ENABLE = 1'b1;
    wait_idle(400, 0, ok);
    ENABLE = 1'b0;
    n_chk += 4;
    if (!ok) $display("FAIL mask_done got=timeout want=idle");
    else n_pass++;
    if (ena_cnt != 32) $display("FAIL mask_pops got=%0d want=32", ena_cnt);
    else n_pass++;
    if (seen.size() != 21) $display("FAIL mask_len got=%0d want=21", seen.size());
    else n_pass++;
    if ((seen.size() > 20 ? seen[20] : 17'hx) !== 17'h1E015)
      $display("FAIL mask_trl got=%h want=1e015", seen.size() > 20 ? seen[20] : 17'hx);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_event();
    test_drdy_random();
    test_enable_drop();
    test_reset_mid();
`ifdef RDSEQ_CHMASK_EN
    test_chmask();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
